// File: rtl/cp0_pkg.sv
// Shared definitions for the CP0 register file: register numbers, exception
// codes, writable-bit masks and the EPC selection helper.
package cp0_pkg;

  // CP0 register numbers
  localparam logic [4:0] CP0_REG_COUNT   = 5'd9;
  localparam logic [4:0] CP0_REG_COMPARE = 5'd11;
  localparam logic [4:0] CP0_REG_STATUS  = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_REG_EPC     = 5'd14;
  localparam logic [4:0] CP0_REG_PRID    = 5'd15;

  // ExcCode values carried in Cause[6:2]
  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  // Software-writable bits: Status IM[15:8], EXL, IE; Cause IP[9:8]
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

  localparam int STATUS_EXL_BIT = 1;

  // A faulting instruction in a delay slot restarts at its branch.
  function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic in_delay);
    return in_delay ? (pc - 32'd4) : pc;
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: free-running Count, Compare, the armed flag and the
// sticky timer interrupt. Only instantiated when CP0_TIMER_EN is defined.
module cp0_timer
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        timer_int_o
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        armed_q, armed_d;
  logic        tint_q, tint_d;

  // Next-state: Count loads or increments; a Compare write re-arms and clears
  // the interrupt, which otherwise latches on an armed match.
  always_comb begin
    count_d   = count_we_i ? wdata_i : (count_q + 32'd1);
    compare_d = compare_q;
    armed_d   = armed_q;
    tint_d    = tint_q;
    if (compare_we_i) begin
      compare_d = wdata_i;
      armed_d   = 1'b1;
      tint_d    = 1'b0;
    end else if (armed_q && (count_q == compare_q)) begin
      tint_d    = 1'b1;
    end
  end

  // Timer state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      compare_q <= '0;
      armed_q   <= 1'b0;
      tint_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      armed_q   <= armed_d;
      tint_q    <= tint_d;
    end
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign timer_int_o = tint_q;

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file at write-back: commits MEM/WB CP0 writes, records
// exception entry and ERET, serves MFC0 reads from registered state only.
// Optional feature macro: CP0_TIMER_EN (Count/Compare timer present).
module cp0_regfile
  import cp0_pkg::*;
#(
  parameter logic [31:0] RESET_STATUS = 32'h1000_0000,
  parameter logic [31:0] PRID_VALUE   = 32'h0001_8000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_i,
  output logic [31:0] rdata_o,
  input  logic [5:0]  int_i,
  input  logic        exc_valid_i,
  input  logic [4:0]  exc_code_i,
  input  logic [31:0] exc_pc_i,
  input  logic        exc_in_delay_i,
  input  logic        eret_i,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        timer_int_o
);

  // Exceptions and ERET take the whole cycle; a coincident write is dropped.
  logic sw_we;
  assign sw_we = we_i & ~exc_valid_i & ~eret_i;

  logic [31:0] count_val;
  logic [31:0] compare_val;
  logic        timer_int;

`ifdef CP0_TIMER_EN
  cp0_timer u_timer (
    .clk          (clk),
    .rst          (rst),
    .count_we_i   (sw_we && (waddr_i == CP0_REG_COUNT)),
    .compare_we_i (sw_we && (waddr_i == CP0_REG_COMPARE)),
    .wdata_i      (wdata_i),
    .count_o      (count_val),
    .compare_o    (compare_val),
    .timer_int_o  (timer_int)
  );
`else
  assign count_val   = '0;
  assign compare_val = '0;
  assign timer_int   = 1'b0;
`endif

  logic [31:0] status_q, status_d;
  logic [31:0] epc_q, epc_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_hw_q, ip_hw_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [4:0]  exc_code_q, exc_code_d;

  // Next-state for Status/Cause/EPC with priority exception > ERET > write.
  always_comb begin
    status_d   = status_q;
    epc_d      = epc_q;
    bd_d       = bd_q;
    ip_sw_d    = ip_sw_q;
    exc_code_d = exc_code_q;
    ip_hw_d    = {int_i[5] | timer_int, int_i[4:0]};
    if (exc_valid_i) begin
      exc_code_d = exc_code_i;
      if (!status_q[STATUS_EXL_BIT]) begin
        epc_d = epc_of(exc_pc_i, exc_in_delay_i);
        bd_d  = exc_in_delay_i;
      end
      status_d[STATUS_EXL_BIT] = 1'b1;
    end else if (eret_i) begin
      status_d[STATUS_EXL_BIT] = 1'b0;
    end else if (sw_we) begin
      case (waddr_i)
        CP0_REG_STATUS: status_d = (wdata_i & STATUS_WMASK) | (RESET_STATUS & ~STATUS_WMASK);
        CP0_REG_CAUSE:  ip_sw_d  = wdata_i[9:8];
        CP0_REG_EPC:    epc_d    = wdata_i;
        default: ;
      endcase
    end
  end

  // Architectural CP0 state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q   <= RESET_STATUS;
      epc_q      <= '0;
      bd_q       <= 1'b0;
      ip_hw_q    <= '0;
      ip_sw_q    <= '0;
      exc_code_q <= '0;
    end else begin
      status_q   <= status_d;
      epc_q      <= epc_d;
      bd_q       <= bd_d;
      ip_hw_q    <= ip_hw_d;
      ip_sw_q    <= ip_sw_d;
      exc_code_q <= exc_code_d;
    end
  end

  assign status_o    = status_q;
  assign cause_o     = {bd_q, 15'b0, ip_hw_q, ip_sw_q, 1'b0, exc_code_q, 2'b00};
  assign epc_o       = epc_q;
  assign count_o     = count_val;
  assign compare_o   = compare_val;
  assign timer_int_o = timer_int;

  // MFC0 read mux over registered state; unimplemented numbers read 0.
  always_comb begin
    rdata_o = '0;
    case (raddr_i)
      CP0_REG_COUNT:   rdata_o = count_val;
      CP0_REG_COMPARE: rdata_o = compare_val;
      CP0_REG_STATUS:  rdata_o = status_q;
      CP0_REG_CAUSE:   rdata_o = cause_o;
      CP0_REG_EPC:     rdata_o = epc_q;
      CP0_REG_PRID:    rdata_o = PRID_VALUE;
      default:         rdata_o = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_regfile.sv
// Self-checking bench for cp0_regfile; expectations go into a scoreboard
// queue as stimulus is driven and are popped against sampled DUT outputs.
module tb_cp0_regfile;
  import cp0_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic [4:0]  raddr_i;
  logic [31:0] rdata_o;
  logic [5:0]  int_i;
  logic        exc_valid_i;
  logic [4:0]  exc_code_i;
  logic [31:0] exc_pc_i;
  logic        exc_in_delay_i;
  logic        eret_i;
  logic [31:0] status_o, cause_o, epc_o, count_o, compare_o;
  logic        timer_int_o;

  cp0_regfile dut (
    .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .raddr_i(raddr_i), .rdata_o(rdata_o), .int_i(int_i),
    .exc_valid_i(exc_valid_i), .exc_code_i(exc_code_i), .exc_pc_i(exc_pc_i),
    .exc_in_delay_i(exc_in_delay_i), .eret_i(eret_i),
    .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o),
    .count_o(count_o), .compare_o(compare_o), .timer_int_o(timer_int_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;

  sb_t         sb[$];
  logic [31:0] obs_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  localparam logic [31:0] RST_STATUS = 32'h1000_0000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string name, input logic [31:0] exp, input logic [31:0] obs);
    sb.push_back('{name, exp});
    obs_q.push_back(obs);
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] v);
    raddr_i = a;
    #1;
    v = rdata_o;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    we_i = 1'b1; waddr_i = a; wdata_i = d;
    tick();
    we_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0]  addrs [0:8];
    logic [31:0] exps  [0:8];
    logic [31:0] v;
    sb_t e;
    addrs = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd0, 5'd3, 5'd31};
    exps  = '{32'h0, 32'h0, 32'h1000_0000, 32'h0, 32'h0, 32'h0001_8000, 32'h0, 32'h0, 32'h0};
    rst = 1'b1;
    #3;
    for (int i = 0; i < 9; i++) begin
      rd(addrs[i], v);
      expect_val($sformatf("reset_rd%0d", addrs[i]), exps[i], v);
    end
    expect_val("reset_tint", 32'h0, {31'b0, timer_int_o});
    @(negedge clk) rst = 1'b0;
    for (int c = 0; c < 100; c++) begin
      tick();
      expect_val($sformatf("idle_tint_c%0d", c), 32'h0, {31'b0, timer_int_o});
    end
    while (sb.size() > 0) begin
      e = sb.pop_front(); v = obs_q.pop_front(); n_cmp++;
      if (v !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", e.name, v, e.exp);
      end
    end
  endtask

  task automatic test_timer();
    logic [31:0] v;
    sb_t e;
`ifdef CP0_TIMER_EN
    logic [31:0] exp_cnt;
    logic        exp_t;
    do_write(CP0_REG_COMPARE, 32'd20);
    do_write(CP0_REG_COUNT, 32'd10);
    exp_cnt = 32'd10;
    exp_t   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      expect_val($sformatf("tmr_count_%0d", i), exp_cnt, count_o);
      expect_val($sformatf("tmr_int_at_%0d", exp_cnt), {31'b0, exp_t}, {31'b0, timer_int_o});
      exp_t   = exp_t | (exp_cnt == 32'd20);
      exp_cnt = exp_cnt + 32'd1;
      tick();
    end
    do_write(CP0_REG_COMPARE, 32'd50);
    expect_val("tmr_clear_on_cmp_wr", 32'h0, {31'b0, timer_int_o});
    rd(CP0_REG_COMPARE, v);
    expect_val("tmr_rd_compare", 32'd50, v);
    do_write(CP0_REG_COUNT, 32'd48);
    tick();
    tick();
    expect_val("tmr_count_at_match", 32'd50, count_o);
    do_write(CP0_REG_COMPARE, 32'h8000_0000);
    expect_val("tmr_coincident_wr_wins", 32'h0, {31'b0, timer_int_o});
    expect_val("tmr_compare_new", 32'h8000_0000, compare_o);
    tick();
    expect_val("tmr_coincident_still0", 32'h0, {31'b0, timer_int_o});
    do_write(CP0_REG_COUNT, 32'hFFFF_FFFF);
    expect_val("tmr_count_max", 32'hFFFF_FFFF, count_o);
    tick();
    expect_val("tmr_count_wrap", 32'h0, count_o);
    expect_val("tmr_wrap_noint", 32'h0, {31'b0, timer_int_o});
`else
    do_write(CP0_REG_COMPARE, 32'd20);
    do_write(CP0_REG_COUNT, 32'd10);
    expect_val("notmr_count_o", 32'h0, count_o);
    expect_val("notmr_compare_o", 32'h0, compare_o);
    rd(CP0_REG_COUNT, v);
    expect_val("notmr_rd_count", 32'h0, v);
    rd(CP0_REG_COMPARE, v);
    expect_val("notmr_rd_compare", 32'h0, v);
    for (int i = 0; i < 30; i++) begin
      tick();
      expect_val($sformatf("notmr_tint_%0d", i), 32'h0, {31'b0, timer_int_o});
    end
`endif
    while (sb.size() > 0) begin
      e = sb.pop_front(); v = obs_q.pop_front(); n_cmp++;
      if (v !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", e.name, v, e.exp);
      end
    end
  endtask

  task automatic test_status_cause();
    logic [31:0] v;
    sb_t e;
    do_write(CP0_REG_STATUS, 32'hFFFF_FFFF);
    rd(CP0_REG_STATUS, v);
    expect_val("status_all_ones", 32'h1000_FF03, v);
    do_write(CP0_REG_CAUSE, 32'hFFFF_FFFF);
    rd(CP0_REG_CAUSE, v);
    expect_val("cause_all_ones", 32'h0000_0300, v);
    do_write(CP0_REG_STATUS, 32'h0000_0000);
    expect_val("status_zero", RST_STATUS, status_o);
    do_write(CP0_REG_CAUSE, 32'h0000_0000);
    expect_val("cause_zero", 32'h0, cause_o);
    do_write(CP0_REG_STATUS, 32'h0000_A501);
    expect_val("status_pattern", 32'h1000_A501, status_o);
    do_write(CP0_REG_STATUS, 32'h0000_0000);
    do_write(5'd3, 32'hFFFF_FFFF);
    rd(5'd3, v);
    expect_val("unimpl_rd3", 32'h0, v);
    do_write(CP0_REG_PRID, 32'h0);
    rd(CP0_REG_PRID, v);
    expect_val("prid_ro", 32'h0001_8000, v);
    while (sb.size() > 0) begin
      e = sb.pop_front(); v = obs_q.pop_front(); n_cmp++;
      if (v !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", e.name, v, e.exp);
      end
    end
  endtask

  task automatic test_exception();
    logic [31:0] v;
    sb_t e;
    // Delay-slot exception with a coincident (dropped) EPC write
    exc_valid_i = 1'b1; exc_code_i = EXC_SYS; exc_pc_i = 32'hBFC0_0100; exc_in_delay_i = 1'b1;
    we_i = 1'b1; waddr_i = CP0_REG_EPC; wdata_i = 32'h1111_1111;
    tick();
    exc_valid_i = 1'b0; we_i = 1'b0;
    rd(CP0_REG_EPC, v);
    expect_val("exc1_epc", 32'hBFC0_00FC, v);
    expect_val("exc1_cause", 32'h8000_0020, cause_o);
    expect_val("exc1_status", 32'h1000_0002, status_o);
    // Nested exception while EXL=1
    exc_valid_i = 1'b1; exc_code_i = EXC_ADEL; exc_pc_i = 32'h0000_1234; exc_in_delay_i = 1'b0;
    tick();
    exc_valid_i = 1'b0;
    expect_val("exc2_epc_hold", 32'hBFC0_00FC, epc_o);
    expect_val("exc2_cause", 32'h8000_0010, cause_o);
    expect_val("exc2_status", 32'h1000_0002, status_o);
    // ERET with a coincident (dropped) EPC write
    eret_i = 1'b1; we_i = 1'b1; waddr_i = CP0_REG_EPC; wdata_i = 32'hDEAD_BEEF;
    tick();
    eret_i = 1'b0; we_i = 1'b0;
    expect_val("eret_epc_hold", 32'hBFC0_00FC, epc_o);
    expect_val("eret_status", RST_STATUS, status_o);
    // Non-delay-slot exception from EXL=0
    exc_valid_i = 1'b1; exc_code_i = EXC_OV; exc_pc_i = 32'h0000_2000; exc_in_delay_i = 1'b0;
    tick();
    exc_valid_i = 1'b0;
    expect_val("exc3_epc", 32'h0000_2000, epc_o);
    expect_val("exc3_cause", 32'h0000_0030, cause_o);
    eret_i = 1'b1;
    tick();
    eret_i = 1'b0;
    // Exception beats a simultaneous ERET
    exc_valid_i = 1'b1; eret_i = 1'b1; exc_code_i = EXC_RI; exc_pc_i = 32'h0000_3000;
    tick();
    exc_valid_i = 1'b0; eret_i = 1'b0;
    expect_val("exc_over_eret_status", 32'h1000_0002, status_o);
    expect_val("exc_over_eret_epc", 32'h0000_3000, epc_o);
    expect_val("exc_over_eret_cause", 32'h0000_0028, cause_o);
    eret_i = 1'b1;
    tick();
    eret_i = 1'b0;
    expect_val("eret2_status", RST_STATUS, status_o);
    while (sb.size() > 0) begin
      e = sb.pop_front(); v = obs_q.pop_front(); n_cmp++;
      if (v !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", e.name, v, e.exp);
      end
    end
  endtask

  task automatic test_interrupt();
    logic [31:0] v;
    sb_t e;
    logic [5:0] pats [0:3];
    logic [5:0] prev;
    pats = '{6'b000001, 6'b100000, 6'b010110, 6'b000000};
    prev = 6'b000000;
    for (int i = 0; i < 4; i++) begin
      int_i = pats[i];
      #1;
      expect_val($sformatf("ip_lag_%0d", i), {26'b0, prev}, {26'b0, cause_o[15:10]});
      tick();
      expect_val($sformatf("ip_after_%0d", i), {26'b0, pats[i]}, {26'b0, cause_o[15:10]});
      prev = pats[i];
    end
    while (sb.size() > 0) begin
      e = sb.pop_front(); v = obs_q.pop_front(); n_cmp++;
      if (v !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", e.name, v, e.exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    logic [31:0] model_epc;
    logic [31:0] vals [0:3];
    sb_t e;
    vals = '{32'hA5A5_0001, 32'h5A5A_0002, 32'h0000_0004, 32'hFFFF_FFF8};
    model_epc = epc_o;
    raddr_i = CP0_REG_EPC;
    for (int i = 0; i < 4; i++) begin
      we_i = 1'b1; waddr_i = CP0_REG_EPC; wdata_i = vals[i];
      #1;
      expect_val($sformatf("b2b_no_bypass_%0d", i), model_epc, rdata_o);
      tick();
      model_epc = vals[i];
    end
    we_i = 1'b0;
    #1;
    expect_val("b2b_final", model_epc, rdata_o);
    while (sb.size() > 0) begin
      e = sb.pop_front(); v = obs_q.pop_front(); n_cmp++;
      if (v !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", e.name, v, e.exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    sb_t e;
    do_write(CP0_REG_STATUS, 32'h0000_FF01);
    do_write(CP0_REG_CAUSE, 32'h0000_0300);
`ifdef CP0_TIMER_EN
    do_write(CP0_REG_COMPARE, 32'd100);
    do_write(CP0_REG_COUNT, 32'd98);
    tick();
    tick();
    tick();
    expect_val("mid_pre_tint", 32'h1, {31'b0, timer_int_o});
`endif
    #2 rst = 1'b1;
    #1;
    expect_val("mid_count", 32'h0, count_o);
    expect_val("mid_compare", 32'h0, compare_o);
    expect_val("mid_tint", 32'h0, {31'b0, timer_int_o});
    expect_val("mid_status", RST_STATUS, status_o);
    expect_val("mid_cause", 32'h0, cause_o);
    expect_val("mid_epc", 32'h0, epc_o);
    @(negedge clk) rst = 1'b0;
    tick();
`ifdef CP0_TIMER_EN
    expect_val("post_rst_count", 32'h1, count_o);
`else
    expect_val("post_rst_count", 32'h0, count_o);
`endif
    expect_val("post_rst_tint", 32'h0, {31'b0, timer_int_o});
    while (sb.size() > 0) begin
      e = sb.pop_front(); v = obs_q.pop_front(); n_cmp++;
      if (v !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", e.name, v, e.exp);
      end
    end
  endtask

  initial begin
    rst = 1'b1; we_i = 1'b0; waddr_i = '0; wdata_i = '0; raddr_i = '0;
    int_i = '0; exc_valid_i = 1'b0; exc_code_i = '0; exc_pc_i = '0;
    exc_in_delay_i = 1'b0; eret_i = 1'b0;
    test_reset();
    test_timer();
    test_status_cause();
    test_exception();
    test_interrupt();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
